// File: rtl/rr_sel5_arbiter.sv
// rr_sel5_arbiter: round-robin arbiter driving a 5:1 byte selector, capturing its output onto a valid/ready port
module rr_sel5_arbiter #(
  parameter int DATA_W = 8,
  parameter int NCH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  output logic [2:0]        sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [NCH-1:0]    gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [2:0]        out_ch
);
  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d, last_q, last_d, out_ch_q, out_ch_d, win;
  logic [3:0] idx;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  // circular scan starting after the last served channel; nearest hit overwrites last
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = 4'(last_q) + 4'(k);
      idx = (idx >= 4'(NCH)) ? idx - 4'(NCH) : idx;
      if (req[idx[2:0]]) win = idx[2:0];
    end
  end
  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    gnt_d = '0;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_ch_d = out_ch_q;
    case (state_q)
      IDLE: begin
        sel_d = |req ? win : sel_q;
        state_d = |req ? SETTLE : IDLE;
      end
      SETTLE: begin
        out_data_d = mux_data;
        out_ch_d = sel_q;
        out_valid_d = 1'b1;
        gnt_d = NCH'(1) << sel_q;
        last_d = sel_q;
        state_d = OUT;
      end
      default: begin
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        state_d = out_ready ? IDLE : OUT;
      end
    endcase
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      last_q <= 3'(NCH - 1);
      gnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
    end
  end
  assign sel = sel_q;
  assign gnt = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule
